// File: rtl/gpu_cache_fill_ctrl_pkg.sv
// Shared definitions for the Tex$/Clut$ line-fill controller.
`timescale 1ns/1ps
package gpu_cache_fill_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA  = 3'd2,
        DONE  = 3'd3,
        GUARD = 3'd4
    } fillState_t;

    localparam int TEX_LINE_WORDS  = 2;
    localparam int CLUT_LINE_WORDS = 8;

    localparam logic SEL_TEX  = 1'b0;
    localparam logic SEL_CLUT = 1'b1;

endpackage

// File: rtl/gpu_cache_fill_ctrl.sv
// Arbitrates Tex$/Clut$ misses, issues one VRAM burst per fill and streams the
// returned words into the requesting cache, then pulses its completion strobe.
//
// state | meaning
// IDLE  | waiting for a miss; Tex$ wins when both are raised
// REQ   | burst request held on the VRAM port until acknowledged
// DATA  | beats written to the selected cache; left one cycle after the last write
// DONE  | completion strobe for the selected cache
// GUARD | one cycle of ignoring requests so the served miss level has dropped
`timescale 1ns/1ps
module gpu_cache_fill_ctrl
    import gpu_cache_fill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst,

    input  logic        requTexCacheUpdate,
    input  logic [16:0] adrTexCacheUpdate,
    output logic        updateTexCacheComplete,

    input  logic        requClutCacheUpdate,
    input  logic [14:0] adrClutCacheUpdate,
    output logic        updateClutCacheComplete,

    output logic        o_rdReq,
    output logic [17:0] o_rdAdr,
    output logic [3:0]  o_rdLen,
    input  logic        i_rdAck,
    input  logic        i_rdValid,
    input  logic [31:0] i_rdData,

    output logic        o_texWrEn,
    output logic [16:0] o_texWrAdr,
    output logic        o_texWrIdx,
    output logic        o_clutWrEn,
    output logic [14:0] o_clutWrAdr,
    output logic [2:0]  o_clutWrIdx,
    output logic [31:0] o_wrData,

    output logic        o_busy
);

    fillState_t  state;
    fillState_t  stateNext;
    logic        sel;
    logic [16:0] texAdr;
    logic [14:0] clutAdr;
    logic [3:0]  beatCnt;
    logic [3:0]  lineLen;
    logic        beatAccept;

    assign lineLen    = (sel == SEL_CLUT) ? 4'(CLUT_LINE_WORDS) : 4'(TEX_LINE_WORDS);
    // beatCnt reaching lineLen marks the line as full; further beats are dropped
    assign beatAccept = (state == DATA) && i_rdValid && (beatCnt != lineLen);

    assign o_texWrAdr  = texAdr;
    assign o_clutWrAdr = clutAdr;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext               = state;
        o_rdReq                 = 1'b0;
        o_rdAdr                 = 18'd0;
        o_rdLen                 = 4'd0;
        updateTexCacheComplete  = 1'b0;
        updateClutCacheComplete = 1'b0;
        o_busy                  = (state != IDLE);

        case (state)
            IDLE: begin
                if (requTexCacheUpdate || requClutCacheUpdate) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                o_rdReq = 1'b1;
                o_rdLen = lineLen;
                if (sel == SEL_CLUT) begin
                    o_rdAdr = {clutAdr, 3'b000};
                end else begin
                    o_rdAdr = {texAdr, 1'b0};
                end
                if (i_rdAck) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                // Waiting for the full count keeps completion one cycle behind the last write.
                if (beatCnt == lineLen) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                updateTexCacheComplete  = (sel == SEL_TEX);
                updateClutCacheComplete = (sel == SEL_CLUT);
                stateNext               = GUARD;
            end
            GUARD: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sel         <= SEL_TEX;
            texAdr      <= 17'd0;
            clutAdr     <= 15'd0;
            beatCnt     <= 4'd0;
            o_texWrEn   <= 1'b0;
            o_texWrIdx  <= 1'b0;
            o_clutWrEn  <= 1'b0;
            o_clutWrIdx <= 3'd0;
            o_wrData    <= 32'd0;
        end else begin
            o_texWrEn  <= 1'b0;
            o_clutWrEn <= 1'b0;

            if (state == IDLE) begin
                beatCnt <= 4'd0;
                if (requTexCacheUpdate) begin
                    sel    <= SEL_TEX;
                    texAdr <= adrTexCacheUpdate;
                end else if (requClutCacheUpdate) begin
                    sel     <= SEL_CLUT;
                    clutAdr <= adrClutCacheUpdate;
                end
            end

            if (state == REQ) begin
                beatCnt <= 4'd0;
            end

            if (beatAccept) begin
                beatCnt     <= beatCnt + 4'd1;
                o_texWrEn   <= (sel == SEL_TEX);
                o_clutWrEn  <= (sel == SEL_CLUT);
                o_texWrIdx  <= beatCnt[0];
                o_clutWrIdx <= beatCnt[2:0];
                o_wrData    <= i_rdData;
            end
        end
    end

endmodule

// File: tb/tb_gpu_cache_fill_ctrl.sv
// Directed bench for gpu_cache_fill_ctrl with write/burst scoreboards.
`timescale 1ns/1ps
module tb_gpu_cache_fill_ctrl;

    logic        clk;
    logic        i_rst;
    logic        requTexCacheUpdate;
    logic [16:0] adrTexCacheUpdate;
    logic        updateTexCacheComplete;
    logic        requClutCacheUpdate;
    logic [14:0] adrClutCacheUpdate;
    logic        updateClutCacheComplete;
    logic        o_rdReq;
    logic [17:0] o_rdAdr;
    logic [3:0]  o_rdLen;
    logic        i_rdAck;
    logic        i_rdValid;
    logic [31:0] i_rdData;
    logic        o_texWrEn;
    logic [16:0] o_texWrAdr;
    logic        o_texWrIdx;
    logic        o_clutWrEn;
    logic [14:0] o_clutWrAdr;
    logic [2:0]  o_clutWrIdx;
    logic [31:0] o_wrData;
    logic        o_busy;

    gpu_cache_fill_ctrl dut (
        .clk                     (clk),
        .i_rst                   (i_rst),
        .requTexCacheUpdate      (requTexCacheUpdate),
        .adrTexCacheUpdate       (adrTexCacheUpdate),
        .updateTexCacheComplete  (updateTexCacheComplete),
        .requClutCacheUpdate     (requClutCacheUpdate),
        .adrClutCacheUpdate      (adrClutCacheUpdate),
        .updateClutCacheComplete (updateClutCacheComplete),
        .o_rdReq                 (o_rdReq),
        .o_rdAdr                 (o_rdAdr),
        .o_rdLen                 (o_rdLen),
        .i_rdAck                 (i_rdAck),
        .i_rdValid               (i_rdValid),
        .i_rdData                (i_rdData),
        .o_texWrEn               (o_texWrEn),
        .o_texWrAdr              (o_texWrAdr),
        .o_texWrIdx              (o_texWrIdx),
        .o_clutWrEn              (o_clutWrEn),
        .o_clutWrAdr             (o_clutWrAdr),
        .o_clutWrIdx             (o_clutWrIdx),
        .o_wrData                (o_wrData),
        .o_busy                  (o_busy)
    );

    typedef struct {
        logic        isClut;
        logic [16:0] adr;
        logic [2:0]  idx;
        logic [31:0] data;
    } wrExp_t;

    typedef struct {
        logic [17:0] adr;
        logic [3:0]  len;
    } burstExp_t;

    wrExp_t    wrQ[$];
    burstExp_t burstQ[$];
    wrExp_t    eW;
    burstExp_t eB;

    int cmpCnt     = 0;
    int errCnt     = 0;
    int burstCnt   = 0;
    int texDoneCnt = 0;
    int clutDoneCnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pops expectations as the DUT writes or starts bursts.
    always @(negedge clk) begin
        if (o_texWrEn || o_clutWrEn) begin
            check("wrQueueNotEmpty", 32'(wrQ.size() != 0), 32'd1);
            if (wrQ.size() != 0) begin
                eW = wrQ.pop_front();
                check("wrOneHot", 32'(o_texWrEn ^ o_clutWrEn), 32'd1);
                check("wrTarget", 32'(o_clutWrEn), 32'(eW.isClut));
                check("wrData", o_wrData, eW.data);
                if (eW.isClut) begin
                    check("clutWrIdx", 32'(o_clutWrIdx), 32'(eW.idx));
                    check("clutWrAdr", 32'(o_clutWrAdr), 32'(eW.adr[14:0]));
                end else begin
                    check("texWrIdx", 32'(o_texWrIdx), 32'(eW.idx[0]));
                    check("texWrAdr", 32'(o_texWrAdr), 32'(eW.adr));
                end
            end
        end
        if (o_rdReq && i_rdAck) begin
            burstCnt++;
            check("burstQueueNotEmpty", 32'(burstQ.size() != 0), 32'd1);
            if (burstQ.size() != 0) begin
                eB = burstQ.pop_front();
                check("rdAdr", 32'(o_rdAdr), 32'(eB.adr));
                check("rdLen", 32'(o_rdLen), 32'(eB.len));
            end
        end
        if (updateTexCacheComplete)  texDoneCnt++;
        if (updateClutCacheComplete) clutDoneCnt++;
    end

    task automatic runFill(input logic isClut, input logic [16:0] adr, input int ackDelay,
                           input int maxGap, input logic strayInReq, input int nBeats,
                           input logic doFinish, input logic [31:0] d0, input logic [31:0] d1);
        burstExp_t bx;
        wrExp_t    w;
        int        waitCnt;
        int        gap;
        logic [31:0] data;
        bx.adr = isClut ? {adr[14:0], 3'b000} : {adr, 1'b0};
        bx.len = isClut ? 4'd8 : 4'd2;
        burstQ.push_back(bx);
        waitCnt = 0;
        @(negedge clk);
        while (!o_rdReq && waitCnt < 64) begin
            @(negedge clk);
            waitCnt++;
        end
        check("rdReqSeen", 32'(o_rdReq), 32'd1);
        if (!o_rdReq) return;
        // Scramble the served address input; the latched one must not follow.
        if (isClut) adrClutCacheUpdate = 15'($urandom);
        else        adrTexCacheUpdate  = 17'($urandom);
        if (ackDelay == 0) begin
            i_rdAck = 1'b1;
        end else begin
            for (int k = 1; k < ackDelay; k++) begin
                tick();
                i_rdValid = strayInReq && (k == 1);
                i_rdData  = 32'hBAD0BAD0;
                @(negedge clk);
                check("rdReqHeld", 32'(o_rdReq), 32'd1);
                check("rdAdrStable", 32'(o_rdAdr), 32'(bx.adr));
                check("rdLenStable", 32'(o_rdLen), 32'(bx.len));
            end
            tick();
            i_rdValid = 1'b0;
            i_rdAck   = 1'b1;
        end
        @(negedge clk);
        check("rdReqAtAck", 32'(o_rdReq), 32'd1);
        tick();
        i_rdAck = 1'b0;
        for (int k = 0; k < nBeats; k++) begin
            gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
            repeat (gap) tick();
            data = (k == 0) ? d0 : (k == 1) ? d1 : $urandom;
            w.isClut = isClut;
            w.adr    = adr;
            w.idx    = 3'(k);
            w.data   = data;
            wrQ.push_back(w);
            i_rdValid = 1'b1;
            i_rdData  = data;
            tick();
            i_rdValid = 1'b0;
        end
        if (doFinish) begin
            @(negedge clk);
            check("texCompleteEarly", 32'(updateTexCacheComplete), 32'd0);
            check("clutCompleteEarly", 32'(updateClutCacheComplete), 32'd0);
            tick();
            @(negedge clk);
            check("texComplete", 32'(updateTexCacheComplete), 32'(!isClut));
            check("clutComplete", 32'(updateClutCacheComplete), 32'(isClut));
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_rdReq"}, 32'(o_rdReq), 32'd0);
        check({tag, "_rdAdr"}, 32'(o_rdAdr), 32'd0);
        check({tag, "_rdLen"}, 32'(o_rdLen), 32'd0);
        check({tag, "_wrEn"}, 32'({o_texWrEn, o_clutWrEn}), 32'd0);
        check({tag, "_wrAdr"}, 32'({o_texWrAdr, o_clutWrAdr}), 32'd0);
        check({tag, "_wrIdx"}, 32'({o_texWrIdx, o_clutWrIdx}), 32'd0);
        check({tag, "_wrData"}, o_wrData, 32'd0);
        check({tag, "_complete"}, 32'({updateTexCacheComplete, updateClutCacheComplete}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst               = 1'b1;
        requTexCacheUpdate  = 1'b0;
        adrTexCacheUpdate   = 17'd0;
        requClutCacheUpdate = 1'b0;
        adrClutCacheUpdate  = 15'd0;
        i_rdAck             = 1'b0;
        i_rdValid           = 1'b0;
        i_rdData            = 32'd0;
        repeat (2) tick();
        @(negedge clk);
        checkAllZero("reset");
        tick();
        i_rst = 1'b0;
        tick();

        // Tex fill with delayed ack
        requTexCacheUpdate = 1'b1;
        adrTexCacheUpdate  = 17'h1ABCD;
        @(negedge clk);
        check("reqLatency", 32'(o_rdReq), 32'd0);
        runFill(1'b0, 17'h1ABCD, 3, 0, 1'b0, 2, 1'b1, 32'h11112222, 32'h33334444);
        tick();
        requTexCacheUpdate = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t1Bursts", 32'(burstCnt), 32'd1);
        check("t1TexDone", 32'(texDoneCnt), 32'd1);
        check("t1Idle", 32'(o_busy), 32'd0);

        // Clut fill with random beat gaps
        requClutCacheUpdate = 1'b1;
        adrClutCacheUpdate  = 15'h1234;
        runFill(1'b1, 17'h01234, 1, 3, 1'b0, 8, 1'b1, $urandom, $urandom);
        tick();
        requClutCacheUpdate = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t2Bursts", 32'(burstCnt), 32'd2);
        check("t2ClutDone", 32'(clutDoneCnt), 32'd1);
        check("t2TexDone", 32'(texDoneCnt), 32'd1);

        // Simultaneous requests: Tex first, Clut served after GUARD
        requTexCacheUpdate  = 1'b1;
        adrTexCacheUpdate   = 17'h0F0F1;
        requClutCacheUpdate = 1'b1;
        adrClutCacheUpdate  = 15'h7ABC;
        runFill(1'b0, 17'h0F0F1, 2, 1, 1'b0, 2, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
        tick();
        requTexCacheUpdate = 1'b0;
        runFill(1'b1, 17'h07ABC, 1, 2, 1'b0, 8, 1'b1, $urandom, $urandom);
        tick();
        requClutCacheUpdate = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("t3Bursts", 32'(burstCnt), 32'd4);
        check("t3TexDone", 32'(texDoneCnt), 32'd2);
        check("t3ClutDone", 32'(clutDoneCnt), 32'd2);

        // Request level held through GUARD: still a single burst
        requTexCacheUpdate = 1'b1;
        adrTexCacheUpdate  = 17'h00042;
        runFill(1'b0, 17'h00042, 1, 0, 1'b0, 2, 1'b1, 32'hCAFEF00D, 32'h0BADF00D);
        tick();
        @(negedge clk);
        check("t4GuardBusy", 32'(o_busy), 32'd1);
        check("t4GuardNoComplete", 32'(updateTexCacheComplete), 32'd0);
        tick();
        requTexCacheUpdate = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("t4Bursts", 32'(burstCnt), 32'd5);
        check("t4TexDone", 32'(texDoneCnt), 32'd3);
        check("t4Idle", 32'(o_busy), 32'd0);

        // Reset after the 3rd Clut beat, then a stray beat in IDLE
        requClutCacheUpdate = 1'b1;
        adrClutCacheUpdate  = 15'h2DEF;
        runFill(1'b1, 17'h02DEF, 1, 0, 1'b0, 3, 1'b0, 32'h01010101, 32'h02020202);
        @(negedge clk);
        check("t5BusyBeforeReset", 32'(o_busy), 32'd1);
        tick();
        i_rst               = 1'b1;
        requClutCacheUpdate = 1'b0;
        tick();
        i_rst = 1'b0;
        @(negedge clk);
        checkAllZero("midReset");
        tick();
        i_rdValid = 1'b1;
        i_rdData  = 32'hDEADBEEF;
        tick();
        i_rdValid = 1'b0;
        @(negedge clk);
        check("t5StrayNoBusy", 32'(o_busy), 32'd0);
        check("t5StrayNoWrite", 32'({o_texWrEn, o_clutWrEn}), 32'd0);
        tick();
        requTexCacheUpdate = 1'b1;
        adrTexCacheUpdate  = 17'h15555;
        runFill(1'b0, 17'h15555, 1, 0, 1'b0, 2, 1'b1, 32'h77778888, 32'h9999AAAA);
        tick();
        requTexCacheUpdate = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t5Bursts", 32'(burstCnt), 32'd7);
        check("t5TexDone", 32'(texDoneCnt), 32'd4);
        check("t5ClutDone", 32'(clutDoneCnt), 32'd2);

        // i_rdValid pulsed in REQ before ack: ignored, first write is idx 0
        requTexCacheUpdate = 1'b1;
        adrTexCacheUpdate  = 17'h00777;
        runFill(1'b0, 17'h00777, 3, 0, 1'b1, 2, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        tick();
        requTexCacheUpdate = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t6Bursts", 32'(burstCnt), 32'd8);
        check("t6TexDone", 32'(texDoneCnt), 32'd5);

        check("wrQueueDrained", 32'(wrQ.size()), 32'd0);
        check("burstQueueDrained", 32'(burstQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
